// File: rtl/nr_pkg.sv
// Shared types and constants for the nr_recip Newton-Raphson reciprocal unit.
// Constant helpers take the fraction width so each instance can size its own copy.
package nr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NORM,
      ST_MUL1,
      ST_MUL2,
      ST_DENORM,
      ST_DONE
   } nr_state_t;

   // round(2.9142 * 2^frac), done in integers so it elaborates without reals
   function automatic logic [63:0] seed_k(input int frac);
      return ((64'd29142 << frac) + 64'd5000) / 64'd10000;
   endfunction

   // 2.0 in Q2.frac
   function automatic logic [63:0] two_q(input int frac);
      return 64'd1 << (frac + 1);
   endfunction

   // Clamp an unsigned magnitude to the largest positive w-bit two's-complement value
   function automatic logic [63:0] sat_mag(input logic [63:0] mag, input int w);
      logic [63:0] lim;
      lim = (64'd1 << (w - 1)) - 64'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/nr_lzc.sv
// Combinational leading-one detector: p is the bit index of the highest set bit of a.
// zero flags an all-zero input, in which case p is 0.
module nr_lzc #(
   parameter int PRECISION = 18,
   parameter int PW        = $clog2(PRECISION)
) (
   input  logic [PRECISION-1:0] a,
   output logic [PW-1:0]        p,
   output logic                 zero
);

   always_comb begin
      p    = '0;
      zero = (a == '0);
      for (int i = 0; i < PRECISION; i++) begin
         if (a[i]) p = PW'(i);
      end
   end

endmodule

// File: rtl/nr_recip.sv
// Iterative Newton-Raphson reciprocal R ~ 2^(2*DECIMAL)/D for signed fixed-point D.
// One operand in flight; both NR half-steps share a single multiplier.
module nr_recip
   import nr_pkg::*;
#(
   parameter int INTEGER   = 10,
   parameter int DECIMAL   = 7,
   parameter int PRECISION = 1 + INTEGER + DECIMAL,
   parameter int ITER      = 3,
   parameter int FRAC      = PRECISION + 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_vld,
   output logic                        in_rdy,
   input  logic signed [PRECISION-1:0] in_d,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic signed [PRECISION-1:0] out_r,
   output logic                        out_dz
);

   localparam int MW = FRAC + 2;
   localparam int PW = $clog2(PRECISION);
   localparam int WW = MW + 2 * DECIMAL;
   localparam logic [MW-1:0] SEED_K = MW'(seed_k(FRAC));
   localparam logic [MW-1:0] TWO_Q  = MW'(two_q(FRAC));
   localparam logic signed [PRECISION-1:0] MAX_POS = {1'b0, {(PRECISION-1){1'b1}}};

   nr_state_t              state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic signed [PRECISION-1:0] out_r_q, out_r_d;
   logic                   out_dz_q, out_dz_d;

   logic                   s_q, s_d;
   logic [PRECISION-1:0]   a_q, a_d;
   logic [PW-1:0]          p_q, p_d;
   logic                   dz_q, dz_d;
   logic [MW-1:0]          m_q, m_d;
   logic [MW-1:0]          x_q, x_d;
   logic [MW-1:0]          t_q, t_d;

   logic [PRECISION-1:0]   a_in;
   logic [PW-1:0]          lz_p;
   logic                   lz_zero;
   logic [7:0]             sh_n;
   logic [MW-1:0]          m_norm;
   logic [MW-1:0]          x_seed;
   logic [MW-1:0]          mul_a;
   logic [2*MW-1:0]        prod;
   logic [MW-1:0]          prod_q;
   logic [7:0]             sh_d;
   logic [WW-1:0]          wide;
   logic [WW-1:0]          mag_w;
   logic [63:0]            sat;
   logic [PRECISION-1:0]   mag_p;
   logic signed [PRECISION-1:0] r_val;

   nr_lzc #(
      .PRECISION(PRECISION),
      .PW       (PW)
   ) u_lzc (
      .a   (a_q),
      .p   (lz_p),
      .zero(lz_zero)
   );

   always_comb begin
      // the most-negative operand maps to 2^(PRECISION-1) as unsigned
      a_in   = in_d[PRECISION-1] ? unsigned'(-in_d) : unsigned'(in_d);

      // normalise a into [0.5,1) and form the linear seed 2.9142 - 2m
      sh_n   = 8'(FRAC - 1) - 8'(lz_p);
      m_norm = MW'(a_q) << sh_n;
      x_seed = SEED_K - (m_norm << 1);

      mul_a  = (state_q == ST_MUL1) ? m_q : t_q;
      prod   = (2*MW)'(mul_a) * (2*MW)'(x_q);
      prod_q = MW'(prod >> FRAC);

      // x * 2^(2*DECIMAL-p-1), truncated to an integer, as one right shift
      sh_d   = 8'(FRAC + 1) + 8'(p_q);
      wide   = WW'(x_q) << (2 * DECIMAL);
      mag_w  = wide >> sh_d;
      sat    = sat_mag(64'(mag_w), PRECISION);
      mag_p  = PRECISION'(sat);
      r_val  = s_q ? -signed'(mag_p) : signed'(mag_p);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      out_r_d  = out_r_q;
      out_dz_d = out_dz_q;
      s_d      = s_q;
      a_d      = a_q;
      p_d      = p_q;
      dz_d     = dz_q;
      m_d      = m_q;
      x_d      = x_q;
      t_d      = t_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_vld) begin
               s_d     = in_d[PRECISION-1];
               a_d     = a_in;
               cnt_d   = 3'd0;
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            p_d     = lz_p;
            dz_d    = lz_zero;
            m_d     = m_norm;
            x_d     = x_seed;
            state_d = lz_zero ? ST_DENORM : ST_MUL1;
         end
         ST_MUL1: begin
            t_d     = TWO_Q - prod_q;
            state_d = ST_MUL2;
         end
         ST_MUL2: begin
            x_d     = prod_q;
            cnt_d   = cnt_q + 3'd1;
            state_d = ((cnt_q + 3'd1) < 3'(ITER)) ? ST_MUL1 : ST_DENORM;
         end
         ST_DENORM: begin
            out_r_d  = dz_q ? MAX_POS : r_val;
            out_dz_d = dz_q;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (out_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         out_r_q  <= '0;
         out_dz_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         out_r_q  <= out_r_d;
         out_dz_q <= out_dz_d;
      end
   end

   // datapath registers are always written before being read, so they carry no reset
   always_ff @(posedge clk) begin
      s_q  <= s_d;
      a_q  <= a_d;
      p_q  <= p_d;
      dz_q <= dz_d;
      m_q  <= m_d;
      x_q  <= x_d;
      t_q  <= t_d;
   end

   assign in_rdy  = (state_q == ST_IDLE);
   assign out_vld = (state_q == ST_DONE);
   assign out_r   = out_r_q;
   assign out_dz  = out_dz_q;

endmodule

// File: tb/tb_nr_recip.sv
// Self-checking bench for nr_recip at default parameters (P=18, DECIMAL=7, ITER=3).
// Expected reciprocals come from plain integer division of 2^14 by |D|.
module tb_nr_recip;

   localparam int P   = 18;
   localparam int DEC = 7;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_vld = 1'b0;
   logic                in_rdy;
   logic signed [P-1:0] in_d = '0;
   logic                out_vld;
   logic                out_rdy = 1'b1;
   logic signed [P-1:0] out_r;
   logic                out_dz;

   int n_checks = 0;
   int n_pass   = 0;
   int acc_cnt  = 0;
   int xfer_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_vld && in_rdy) acc_cnt <= acc_cnt + 1;
      if (out_vld && out_rdy) xfer_cnt <= xfer_cnt + 1;
   end

   nr_recip dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (in_vld),
      .in_rdy (in_rdy),
      .in_d   (in_d),
      .out_vld(out_vld),
      .out_rdy(out_rdy),
      .out_r  (out_r),
      .out_dz (out_dz)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // exact reciprocal truncated toward zero; a zero operand gives the positive limit
   function automatic int model_r(input int d);
      int a;
      a = (d < 0) ? -d : d;
      if (a == 0) return (1 << (P - 1)) - 1;
      return (d < 0) ? -((1 << (2 * DEC)) / a) : ((1 << (2 * DEC)) / a);
   endfunction

   function automatic bit within1(input int r, input int e);
      return (r - e >= -1) && (r - e <= 1);
   endfunction

   // drive one operand, wait for its result, then complete the output transfer
   task automatic run_op(input int d, output int r, output logic dz, output int lat,
                         output bit ok);
      int w;
      w = 0;
      in_d   = P'(d);
      in_vld = 1'b1;
      while (!in_rdy && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      in_d   = P'($urandom);
      lat = 1;
      while (!out_vld && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      ok  = out_vld;
      r   = int'(out_r);
      dz  = out_dz;
      out_rdy = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({in_rdy, out_vld, out_r, out_dz} !== {1'b1, 1'b0, 18'd0, 1'b0})
         $display("FAIL reset_hold: rdy=%b vld=%b r=%0d dz=%b, want rdy=1 vld=0 r=0 dz=0",
                  in_rdy, out_vld, out_r, out_dz);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({in_rdy, out_vld, out_r, out_dz} !== {1'b1, 1'b0, 18'd0, 1'b0})
         $display("FAIL reset_release: rdy=%b vld=%b r=%0d dz=%b, want rdy=1 vld=0 r=0 dz=0",
                  in_rdy, out_vld, out_r, out_dz);
      else n_pass++;
   endtask

   task automatic test_directed();
      int   vec [6] = '{256, -512, 64, 384, 1, -131072};
      int   r, lat, e;
      logic dz;
      bit   ok;
      foreach (vec[i]) begin
         run_op(vec[i], r, dz, lat, ok);
         e = model_r(vec[i]);
         n_checks++;
         if (!ok || !within1(r, e) || dz !== 1'b0)
            $display("FAIL directed d=%0d: ok=%0b r=%0d dz=%b, want r=%0d(+-1) dz=0",
                     vec[i], ok, r, dz, e);
         else n_pass++;
         if (vec[i] == 256) begin
            n_checks++;
            if (lat != 9) $display("FAIL latency d=256: got %0d edges, want 9", lat);
            else n_pass++;
         end
         if (vec[i] == -131072) begin
            n_checks++;
            if (r != 0) $display("FAIL most_negative: got r=%0d, want 0", r);
            else n_pass++;
         end
      end
   endtask

   task automatic test_dz();
      int   r, lat, e;
      logic dz;
      bit   ok;
      run_op(0, r, dz, lat, ok);
      n_checks++;
      if (!ok || r != 131071 || dz !== 1'b1)
         $display("FAIL dz_result: ok=%0b r=%0d dz=%b, want r=131071 dz=1", ok, r, dz);
      else n_pass++;
      n_checks++;
      if (lat != 3) $display("FAIL dz_latency: got %0d edges, want 3", lat);
      else n_pass++;
      run_op(-700, r, dz, lat, ok);
      e = model_r(-700);
      n_checks++;
      if (!ok || !within1(r, e) || dz !== 1'b0 || lat != 9)
         $display("FAIL after_dz d=-700: ok=%0b r=%0d dz=%b lat=%0d, want r=%0d(+-1) dz=0 lat=9",
                  ok, r, dz, lat, e);
      else n_pass++;
   endtask

   task automatic test_random();
      int   d, r, lat, e;
      logic dz;
      bit   ok;
      logic signed [P-1:0] raw;
      for (int i = 0; i < 24; i++) begin
         raw = P'($urandom);
         raw = raw >>> $urandom_range(0, 16);
         d   = int'(raw);
         run_op(d, r, dz, lat, ok);
         e = model_r(d);
         n_checks++;
         if (d == 0) begin
            if (!ok || r != e || dz !== 1'b1)
               $display("FAIL random d=0: ok=%0b r=%0d dz=%b, want r=%0d dz=1", ok, r, dz, e);
            else n_pass++;
         end else begin
            if (!ok || !within1(r, e) || dz !== 1'b0)
               $display("FAIL random d=%0d: ok=%0b r=%0d dz=%b, want r=%0d(+-1) dz=0",
                        d, ok, r, dz, e);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, w, a0, r0, r1;
      d1 = 1000;
      d2 = -90;
      out_rdy = 1'b0;
      in_d    = P'(d1);
      in_vld  = 1'b1;
      w = 0;
      while (!in_rdy && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      in_d = P'(d2);
      a0   = acc_cnt;
      w = 0;
      while (!out_vld && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      r0 = int'(out_r);
      n_checks++;
      if (!out_vld || !within1(r0, model_r(d1)))
         $display("FAIL b2b_first: vld=%b r=%0d, want vld=1 r=%0d(+-1)", out_vld, r0, model_r(d1));
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (in_rdy !== 1'b0 || out_vld !== 1'b1 || int'(out_r) != r0 || out_dz !== 1'b0)
            $display("FAIL b2b_stall cycle %0d: rdy=%b vld=%b r=%0d dz=%b, want rdy=0 vld=1 r=%0d dz=0",
                     c, in_rdy, out_vld, out_r, out_dz, r0);
         else n_pass++;
      end
      n_checks++;
      if (acc_cnt != a0) $display("FAIL b2b_no_accept: accepts=%0d, want %0d", acc_cnt, a0);
      else n_pass++;
      out_rdy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      w = 0;
      while (!out_vld && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      r1 = int'(out_r);
      n_checks++;
      if (!out_vld || !within1(r1, model_r(d2)))
         $display("FAIL b2b_second: vld=%b r=%0d, want vld=1 r=%0d(+-1)", out_vld, r1, model_r(d2));
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (acc_cnt != a0 + 1 || xfer_cnt != acc_cnt)
         $display("FAIL b2b_counts: accepts=%0d transfers=%0d, want accepts=%0d transfers equal",
                  acc_cnt, xfer_cnt, a0 + 1);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      int   r, lat, w;
      logic dz;
      bit   ok, saw_vld;
      in_d   = P'(300);
      in_vld = 1'b1;
      w = 0;
      while (!in_rdy && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0)
         $display("FAIL midop_reset: rdy=%b vld=%b, want rdy=1 vld=0", in_rdy, out_vld);
      else n_pass++;
      @(posedge clk); #3;
      rst_n = 1'b1;
      saw_vld = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_vld) saw_vld = 1'b1;
      end
      n_checks++;
      if (saw_vld) $display("FAIL midop_dropped: out_vld=1 seen, want 0");
      else n_pass++;
      run_op(128, r, dz, lat, ok);
      n_checks++;
      if (!ok || !within1(r, 128) || dz !== 1'b0)
         $display("FAIL midop_next d=128: ok=%0b r=%0d dz=%b, want r=128(+-1) dz=0", ok, r, dz);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_dz();
      test_random();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
